// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state, opcode and control-field encodings for the multi-cycle control unit (CPU_CTRL_JUMP_EN)
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef CPU_CTRL_JUMP_EN
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       memtoreg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/cpu_multicycle_control_if.sv
// rtl/cpu_multicycle_control_if.sv - control unit to datapath signal bundle
interface cpu_multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                iord;
    logic                mem_rd;
    logic                mem_wr;
    logic                ir_write;
    logic                memtoreg;
    logic                Reg_Dst;
    logic                RegWrite;
    logic                AluSrcA;
    logic [1:0]          AluSrcB;
    logic [ALUOP_W-1:0]  ALU_op;
    logic [1:0]          pc_source;
    logic                illegal_op;
    logic [CNT_W-1:0]    retired;
    logic [3:0]          state_o;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_rd, mem_wr, ir_write,
               memtoreg, Reg_Dst, RegWrite, AluSrcA, AluSrcB, ALU_op,
               pc_source, illegal_op, retired, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_rd, mem_wr, ir_write,
               memtoreg, Reg_Dst, RegWrite, AluSrcA, AluSrcB, ALU_op,
               pc_source, illegal_op, retired, state_o
    );
endinterface

// File: rtl/cpu_ctrl_outdec.sv
// rtl/cpu_ctrl_outdec.sv - combinational state to control-word decode (CPU_CTRL_JUMP_EN)
module cpu_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC+4 commit only on the cycle the instruction word arrives
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memtoreg  = 1'b1;
                ctrl.reg_dst   = 1'b0;
            end
            S_MEM_WR: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.memtoreg  = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
                ctrl.memtoreg  = 1'b0;
            end
`ifdef CPU_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle_control.sv
// rtl/cpu_multicycle_control.sv - multi-cycle FSM control unit with stall, illegal-op flag and retire counter (CPU_CTRL_JUMP_EN)
module cpu_multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_multicycle_control_if.master bus
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    ctrl_t               ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        retired_d = retired_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // MEM_ADDR needs to know lw vs sw after the IR field may have moved on
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
`ifdef CPU_CTRL_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`else
                    OP_J: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            S_EXEC:    state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
`ifdef CPU_CTRL_JUMP_EN
            S_JUMP: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    cpu_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_rd        = ctrl.mem_rd;
    assign bus.mem_wr        = ctrl.mem_wr;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.memtoreg      = ctrl.memtoreg;
    assign bus.Reg_Dst       = ctrl.reg_dst;
    assign bus.RegWrite      = ctrl.reg_write;
    assign bus.AluSrcA       = ctrl.alu_src_a;
    assign bus.AluSrcB       = ctrl.alu_src_b;
    assign bus.ALU_op        = ALUOP_W'(ctrl.alu_op);
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = illegal_q;
    assign bus.retired       = retired_q;
    assign bus.state_o       = state_q;

endmodule

// File: doc/cpu_multicycle_control.md
Name: cpu_multicycle_control

Overview:
- Successor to the single-cycle opcode decoder: a Moore/registered FSM control unit for the multi-cycle datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.
- Sits between the instruction register opcode field and the shared-ALU/shared-memory datapath; drives the existing alu_control block through ALU_op.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, width of ALU_op to alu_control.
- CNT_W, 32, width of the retired-instruction counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  instruction register [31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- iord  out  1  memory address source: 0=PC, 1=ALUOut.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- ir_write  out  1  load instruction register.
- memtoreg  out  1  writeback source: 1=MDR, 0=ALUOut.
- Reg_Dst  out  1  destination register: 1=rd, 0=rt.
- RegWrite  out  1  register file write.
- AluSrcA  out  1  ALU A: 0=PC, 1=rs.
- AluSrcB  out  2  ALU B: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALU_op  out  ALUOP_W  00=add, 01=sub, 10=funct-decoded.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- retired  out  CNT_W  count of completed instructions.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP.
- Reset (async, any state, mid-instruction included): state=IDLE, retired=0, illegal_op=0. All outputs 0 in IDLE. An in-flight memory request is dropped; mem_rd and mem_wr fall immediately.
- IDLE -> FETCH on the first clock edge after reset deasserts.
- FETCH: mem_rd=1, iord=0, AluSrcA=0, AluSrcB=01, ALU_op=00, pc_source=00.
  - ir_write and pc_write are asserted only while mem_ready=1 (qualified Mealy terms).
  - Stays in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE: AluSrcA=0, AluSrcB=11, ALU_op=00 (branch target precompute). Next state by opcode:
  - lw/sw -> MEM_ADDR; R -> EXEC; beq -> BRANCH; addi -> ADDI_EX; j -> JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 for the following cycle only. Not counted as retired.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, ALU_op=00. -> MEM_RD for lw, MEM_WR for sw, using the opcode latched in DECODE.
- MEM_RD: mem_rd=1, iord=1. Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB: RegWrite=1, memtoreg=1, Reg_Dst=0. -> FETCH; retired++.
- MEM_WR: mem_wr=1, iord=1. Holds until mem_ready=1, then -> FETCH; retired++.
- EXEC: AluSrcA=1, AluSrcB=00, ALU_op=10. -> R_WB.
- R_WB: RegWrite=1, Reg_Dst=1, memtoreg=0. -> FETCH; retired++.
- BRANCH: AluSrcA=1, AluSrcB=00, ALU_op=01, pc_write_cond=1, pc_source=01. -> FETCH; retired++.
- ADDI_EX: AluSrcA=1, AluSrcB=10, ALU_op=00. -> ADDI_WB.
- ADDI_WB: RegWrite=1, Reg_Dst=0, memtoreg=0. -> FETCH; retired++.
- JUMP: pc_write=1, pc_source=10. -> FETCH; retired++.
- Latency in cycles, assuming zero wait states: R=4, addi=4, beq=3, j=3, sw=4, lw=5. Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Unlisted outputs are 0 in every state.
- mem_rd and mem_wr are never both 1.
- retired wraps from all-ones to 0.
- Unreachable state encodings -> IDLE.

Optional Feature:
- CPU_CTRL_JUMP_EN
  - Defined: j is decoded via the JUMP state as described.
  - Undefined: the JUMP state is not built; opcode 000010 is treated as illegal (illegal_op pulse, return to FETCH); pc_source never takes 10.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants;
  - opcode constants;
  - ALU_op, AluSrcB and pc_source encodings.
- One sub-module, cpu_ctrl_outdec: purely combinational state-to-control-word decode, including the mem_ready qualification of ir_write and pc_write.
- The top level holds the state register, the latched opcode, the illegal_op flop and the retired counter.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 and state_o=IDLE during reset; FETCH one edge after release; mem_rd=1.
- opcode=000000, mem_ready=1 constantly -> states FETCH, DECODE, EXEC, R_WB; RegWrite=1 and Reg_Dst=1 in cycle 4; retired 0->1.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; mem_rd=1 and iord=1 throughout the stall; RegWrite=1 and memtoreg=1 in MEM_WB.
- sw then beq back-to-back -> mem_wr=1 only in MEM_WR; pc_write_cond=1 and ALU_op=01 in BRANCH; retired +2 after 7 cycles.
- opcode=111111 -> illegal_op high for exactly 1 cycle; returns to FETCH; retired unchanged. With the macro undefined, 000010 gives the same result.
- Reset asserted while in MEM_WR with mem_ready=0 -> mem_wr drops within the same cycle; state_o=IDLE; retired=0.
